// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: WIDTH-cycle shift-add multiply and restoring divide.
// Optional MULDIV_UNSIGNED_EN enables unsigned MULTU/DIVU on op[1]; otherwise op[1] is ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state_r, state_next_s;

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r, mq_r, opb_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             is_div_r, neg_main_r, neg_rem_r;
  logic             busy_r, done_r, div_zero_r;

  logic             sign_en_s, accept_s, b_zero_div_s;
  logic [WIDTH:0]   add_s, mul_sum_s, trial_s, sub_s;
  logic             ge_s;
  logic [WIDTH-1:0] acc_step_s, mq_step_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

`ifdef MULDIV_UNSIGNED_EN
  assign sign_en_s = ~op[1];
`else
  logic op_hi_unused_s;
  assign op_hi_unused_s = op[1];
  assign sign_en_s      = 1'b1;
`endif

  assign accept_s     = start && ((state_r == IDLE) || (state_r == DONE));
  assign b_zero_div_s = op[0] && (b == ZERO_W);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_next_s = b_zero_div_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = FIX;
        end else begin
          state_next_s = RUN;
        end
      end
      FIX:     state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // One iteration step: {acc,mq} is the product/remainder-quotient pair
  always_comb begin
    add_s     = {1'b0, acc_r} + {1'b0, opb_r};
    mul_sum_s = mq_r[0] ? add_s : {1'b0, acc_r};
    trial_s   = {acc_r, mq_r[WIDTH-1]};
    sub_s     = trial_s - {1'b0, opb_r};
    ge_s      = (trial_s >= {1'b0, opb_r});
    if (is_div_r) begin
      acc_step_s = ge_s ? sub_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
      mq_step_s  = {mq_r[WIDTH-2:0], ge_s};
    end else begin
      acc_step_s = mul_sum_s[WIDTH:1];
      mq_step_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    if (neg_main_r) begin
      prod_fix_s = ~{acc_r, mq_r} + ONE_2W;
      quo_fix_s  = ~mq_r + ONE_W;
    end else begin
      prod_fix_s = {acc_r, mq_r};
      quo_fix_s  = mq_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = ~acc_r + ONE_W;
    end else begin
      rem_fix_s = acc_r;
    end
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= {CW{1'b0}};
      acc_r      <= ZERO_W;
      mq_r       <= ZERO_W;
      opb_r      <= ZERO_W;
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
      is_div_r   <= 1'b0;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            is_div_r   <= op[0];
            div_zero_r <= b_zero_div_s;
            cnt_r      <= CNT_INIT;
            acc_r      <= ZERO_W;
            neg_main_r <= sign_en_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r  <= sign_en_s & a[WIDTH-1];
            // Divide shifts the dividend through mq; multiply shifts the multiplier
            if (op[0]) begin
              mq_r  <= mag(a, sign_en_s);
              opb_r <= mag(b, sign_en_s);
            end else begin
              mq_r  <= mag(b, sign_en_s);
              opb_r <= mag(a, sign_en_s);
            end
          end
        end
        RUN: begin
          acc_r <= acc_step_s;
          mq_r  <= mq_step_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered status outputs, derived from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN) || (state_next_s == FIX);
      done_r <= (state_next_s == DONE);
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule
